// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-state/condition selects,
// instruction opcode/funct values and the execute-state numbers the microstore ROM uses.
package microseq_pkg;

  typedef enum logic [2:0] {
    NS_ENC          = 3'd0,
    NS_FETCH        = 3'd1,
    NS_CR           = 3'd2,
    NS_INCR         = 3'd3,
    NS_COND_CR_INCR = 3'd4,
    NS_COND_CR_ENC  = 3'd5,
    NS_RSVD6        = 3'd6,
    NS_RSVD7        = 3'd7
  } ns_sel_e;

  typedef enum logic [1:0] {
    COND_MOC   = 2'd0,
    COND_BR    = 2'd1,
    COND_ZERO  = 2'd2,
    COND_FALSE = 2'd3
  } cond_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLL  = 6'h00;

  localparam int unsigned ST_ADD  = 10;
  localparam int unsigned ST_ADDU = 11;
  localparam int unsigned ST_SUB  = 12;
  localparam int unsigned ST_AND  = 14;
  localparam int unsigned ST_OR   = 15;
  localparam int unsigned ST_SLT  = 16;
  localparam int unsigned ST_SLL  = 17;
  localparam int unsigned ST_ADDI = 20;
  localparam int unsigned ST_ANDI = 22;
  localparam int unsigned ST_ORI  = 23;
  localparam int unsigned ST_LW   = 40;
  localparam int unsigned ST_SW   = 50;
  localparam int unsigned ST_BEQ  = 60;
  localparam int unsigned ST_BNE  = 61;
  localparam int unsigned ST_J    = 70;
  localparam int unsigned ST_JAL  = 71;

endpackage

// File: rtl/instr_state_encoder.sv
// Maps an instruction word to the first execute state of its microroutine.
// Purely combinational; anything not recognised goes to ILLEGAL_STATE.
module instr_state_encoder
  import microseq_pkg::*;
#(
  parameter int unsigned STATE_W       = 7,
  parameter int unsigned ILLEGAL_STATE = 127
) (
  input  logic [31:0]        ir_i,
  output logic [STATE_W-1:0] state_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode         = ir_i[31:26];
  assign funct          = ir_i[5:0];
  assign unused_ir_bits = ^ir_i[25:6];

  always_comb begin
    state_o = STATE_W'(ILLEGAL_STATE);
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  state_o = STATE_W'(ST_ADD);
          FN_ADDU: state_o = STATE_W'(ST_ADDU);
          FN_SUB:  state_o = STATE_W'(ST_SUB);
          FN_AND:  state_o = STATE_W'(ST_AND);
          FN_OR:   state_o = STATE_W'(ST_OR);
          FN_SLT:  state_o = STATE_W'(ST_SLT);
          FN_SLL:  state_o = STATE_W'(ST_SLL);
          default: state_o = STATE_W'(ILLEGAL_STATE);
        endcase
      end
      OP_ADDI: state_o = STATE_W'(ST_ADDI);
      OP_ANDI: state_o = STATE_W'(ST_ANDI);
      OP_ORI:  state_o = STATE_W'(ST_ORI);
      OP_LW:   state_o = STATE_W'(ST_LW);
      OP_SW:   state_o = STATE_W'(ST_SW);
      OP_BEQ:  state_o = STATE_W'(ST_BEQ);
      OP_BNE:  state_o = STATE_W'(ST_BNE);
      OP_J:    state_o = STATE_W'(ST_J);
      OP_JAL:  state_o = STATE_W'(ST_JAL);
      default: state_o = STATE_W'(ILLEGAL_STATE);
    endcase
  end

endmodule

// File: rtl/microsequencer_next_state.sv
// Microsequencer: selects and registers the next microstore state each clock,
// and keeps the incrementer register (IncR) used for sequential fall-through.
module microsequencer_next_state
  import microseq_pkg::*;
#(
  parameter int unsigned STATE_W       = 7,
  parameter int unsigned RESET_STATE   = 0,
  parameter int unsigned FETCH_STATE   = 1,
  parameter int unsigned ILLEGAL_STATE = 127
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         N,
  input  logic [1:0]         S,
  input  logic               Inv,
  input  logic               IncRld,
  input  logic [STATE_W-1:0] CR,
  input  logic [31:0]        IR,
  input  logic               MOC,
  input  logic               cond,
  input  logic               zero,
  output logic [STATE_W-1:0] curState,
  output logic [STATE_W-1:0] incR
);

  logic [STATE_W-1:0] cur_state_q;
  logic [STATE_W-1:0] incr_q;
  logic [STATE_W-1:0] ns_d;
  logic [STATE_W-1:0] enc_state;
  logic               cond_sel;
  logic               c;

  instr_state_encoder #(
    .STATE_W      (STATE_W),
    .ILLEGAL_STATE(ILLEGAL_STATE)
  ) u_encoder (
    .ir_i   (IR),
    .state_o(enc_state)
  );

  always_comb begin
    cond_sel = 1'b0;
    case (cond_sel_e'(S))
      COND_MOC:   cond_sel = MOC;
      COND_BR:    cond_sel = cond;
      COND_ZERO:  cond_sel = zero;
      COND_FALSE: cond_sel = 1'b0;
      default:    cond_sel = 1'b0;
    endcase
  end

  assign c = cond_sel ^ Inv;

  // incr_q is read here before any same-edge reload, so N=3 with IncRld uses the old value.
  always_comb begin
    ns_d = STATE_W'(RESET_STATE);
    case (ns_sel_e'(N))
      NS_ENC:          ns_d = enc_state;
      NS_FETCH:        ns_d = STATE_W'(FETCH_STATE);
      NS_CR:           ns_d = CR;
      NS_INCR:         ns_d = incr_q;
      NS_COND_CR_INCR: ns_d = c ? CR : incr_q;
      NS_COND_CR_ENC:  ns_d = c ? CR : enc_state;
      default:         ns_d = STATE_W'(RESET_STATE);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state_q <= STATE_W'(RESET_STATE);
      incr_q      <= STATE_W'(RESET_STATE + 1);
    end else begin
      cur_state_q <= ns_d;
      if (IncRld) begin
        incr_q <= ns_d + STATE_W'(1);
      end
    end
  end

  assign curState = cur_state_q;
  assign incR     = incr_q;

endmodule

// File: tb/tb_microsequencer_next_state.sv
// Directed bench for the microsequencer: hand-computed expected states for each scenario.
module tb_microsequencer_next_state;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  N;
  logic [1:0]  S;
  logic        Inv;
  logic        IncRld;
  logic [6:0]  CR;
  logic [31:0] IR;
  logic        MOC;
  logic        cond;
  logic        zero;
  logic [6:0]  curState;
  logic [6:0]  incR;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] IR_LW  = 32'h8C43_0004;
  localparam logic [31:0] IR_ADD = 32'h0022_1820;
  localparam logic [31:0] IR_BAD = 32'hFC00_0000;
  localparam logic [31:0] IR_BEQ = 32'h1022_0003;

  microsequencer_next_state dut (
    .clk     (clk),
    .reset   (reset),
    .N       (N),
    .S       (S),
    .Inv     (Inv),
    .IncRld  (IncRld),
    .CR      (CR),
    .IR      (IR),
    .MOC     (MOC),
    .cond    (cond),
    .zero    (zero),
    .curState(curState),
    .incR    (incR)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; N = 3'd2; CR = 7'd55;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (curState !== 7'd0) $display("FAIL reset_cur cyc%0d got %0d exp 0", i, curState);
      else pass_cnt++;
      total_cnt++;
      if (incR !== 7'd1) $display("FAIL reset_incr cyc%0d got %0d exp 1", i, incR);
      else pass_cnt++;
    end
    reset = 1'b0;
    step();
    total_cnt++;
    if (curState !== 7'd55) $display("FAIL reset_release got %0d exp 55", curState);
    else pass_cnt++;
  endtask

  task automatic test_fetch_decode();
    logic [31:0] irs [7];
    logic [6:0]  exps[7];
    irs = '{IR_LW, IR_ADD, IR_BAD, 32'h0000_002A, 32'h0C00_0000, 32'h0000_0001, 32'hAC00_0000};
    exps = '{7'd40, 7'd10, 7'd127, 7'd16, 7'd71, 7'd127, 7'd50};
    N = 3'd1;
    step();
    total_cnt++;
    if (curState !== 7'd1) $display("FAIL fetch got %0d exp 1", curState);
    else pass_cnt++;
    N = 3'd0;
    for (int i = 0; i < 7; i++) begin
      IR = irs[i];
      step();
      total_cnt++;
      if (curState !== exps[i]) $display("FAIL decode ir=%h got %0d exp %0d", irs[i], curState, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_moc_wait();
    N = 3'd2; CR = 7'd5; IncRld = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd5 || incR !== 7'd6)
      $display("FAIL moc_setup got cur=%0d incr=%0d exp cur=5 incr=6", curState, incR);
    else pass_cnt++;
    N = 3'd4; S = 2'd0; Inv = 1'b1; IncRld = 1'b0; MOC = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (curState !== 7'd5) $display("FAIL moc_wait cyc%0d got %0d exp 5", i, curState);
      else pass_cnt++;
    end
    MOC = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd6) $display("FAIL moc_done got %0d exp 6", curState);
    else pass_cnt++;
    MOC = 1'b0;
  endtask

  task automatic test_branch();
    // incR is 6 from the previous scenario and holds (IncRld=0)
    logic [2:0] ns_v [12];
    logic [1:0] s_v  [12];
    logic       inv_v[12];
    logic       cnd_v[12];
    logic       z_v  [12];
    logic       moc_v[12];
    logic [6:0] exp_v[12];
    ns_v  = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    s_v   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3};
    inv_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cnd_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    z_v   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    moc_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_v = '{7'd62, 7'd60, 7'd60, 7'd62, 7'd62, 7'd6, 7'd6, 7'd62, 7'd62, 7'd6, 7'd6, 7'd60};
    IR = IR_BEQ; CR = 7'd62; IncRld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      N = ns_v[i]; S = s_v[i]; Inv = inv_v[i]; cond = cnd_v[i]; zero = z_v[i]; MOC = moc_v[i];
      step();
      total_cnt++;
      if (curState !== exp_v[i]) $display("FAIL branch vec%0d got %0d exp %0d", i, curState, exp_v[i]);
      else pass_cnt++;
    end
    Inv = 1'b0; cond = 1'b0; zero = 1'b0; MOC = 1'b0;
  endtask

  task automatic test_incrementer();
    N = 3'd2; CR = 7'd127; IncRld = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd127 || incR !== 7'd0)
      $display("FAIL incr_wrap got cur=%0d incr=%0d exp cur=127 incr=0", curState, incR);
    else pass_cnt++;
    N = 3'd3; IncRld = 1'b0;
    step();
    total_cnt++;
    if (curState !== 7'd0 || incR !== 7'd0)
      $display("FAIL incr_follow got cur=%0d incr=%0d exp cur=0 incr=0", curState, incR);
    else pass_cnt++;
    N = 3'd2; CR = 7'd8; IncRld = 1'b1;
    step();
    N = 3'd3; IncRld = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd9 || incR !== 7'd10)
      $display("FAIL incr_rbw got cur=%0d incr=%0d exp cur=9 incr=10", curState, incR);
    else pass_cnt++;
    N = 3'd2; CR = 7'd33; IncRld = 1'b0;
    step();
    total_cnt++;
    if (curState !== 7'd33 || incR !== 7'd10)
      $display("FAIL incr_hold got cur=%0d incr=%0d exp cur=33 incr=10", curState, incR);
    else pass_cnt++;
  endtask

  task automatic test_reserved();
    for (int i = 6; i < 8; i++) begin
      N = 3'd2; CR = 7'd44; IncRld = 1'b0;
      step();
      N = 3'(i); IncRld = (i == 7);
      step();
      total_cnt++;
      if (curState !== 7'd0) $display("FAIL reserved_n%0d got %0d exp 0", i, curState);
      else pass_cnt++;
    end
    total_cnt++;
    if (incR !== 7'd1) $display("FAIL reserved_incr got %0d exp 1", incR);
    else pass_cnt++;
    IncRld = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    N = 3'd2; CR = 7'd5; IncRld = 1'b1;
    step();
    N = 3'd4; S = 2'd0; Inv = 1'b1; IncRld = 1'b0; MOC = 1'b0;
    step();
    total_cnt++;
    if (curState !== 7'd5) $display("FAIL midwait_hold got %0d exp 5", curState);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd0 || incR !== 7'd1)
      $display("FAIL midwait_reset got cur=%0d incr=%0d exp cur=0 incr=1", curState, incR);
    else pass_cnt++;
    reset = 1'b0; MOC = 1'b1;
    step();
    total_cnt++;
    if (curState !== 7'd1) $display("FAIL midwait_after got %0d exp 1", curState);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; N = 3'd0; S = 2'd0; Inv = 1'b0; IncRld = 1'b0; CR = 7'd0;
    IR = 32'h0; MOC = 1'b0; cond = 1'b0; zero = 1'b0;
    #1;
    test_reset();
    test_fetch_decode();
    test_moc_wait();
    test_branch();
    test_incrementer();
    test_reserved();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
